alu8_exec_stage: RTL and testbench

Single-issue execute stage that sits directly upstream of the 8×8-bit register bank. It accepts one register-to-register instruction per handshake and drives the bank's two read-address ports. It computes an 8-bit result and writes it back through the bank's write port. It also tracks write-back latency so that it never reads a register value the bank has not yet made visible.

---
 rtl/alu8_exec_stage.sv | 261 ++++++++++++++++++++++++++
 tb/tb_alu8_exec_stage.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/alu8_exec_stage.sv
// alu8_exec_stage: single-issue 8-bit execute stage in front of an 8x8 register
// bank. Reads two operands, computes ADD/SUB/logic/shift (and optionally MUL),
// writes back, and stalls reads of a register whose write is not yet visible.
// Optional feature macro: ALU8_MUL_EN enables the 8-cycle shift-add multiplier
// for op 111; when undefined, op 111 completes as an illegal op with no effect.
module alu8_exec_stage #(
    parameter int WB_LAT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [2:0] instr_op,
    input  logic [2:0] instr_rd,
    input  logic [2:0] instr_rs1,
    input  logic [2:0] instr_rs2,
    output logic [2:0] reg_addr_1,
    output logic [2:0] reg_addr_2,
    input  logic [7:0] reg_data_1,
    input  logic [7:0] reg_data_2,
    output logic       write_enable,
    output logic [2:0] write_addr,
    output logic [7:0] write_data,
    output logic       done,
    output logic       op_illegal,
    output logic       flag_zero,
    output logic       flag_carry
);

    // Pending counter only needs to hold WB_LAT-1.
    localparam int CW = (WB_LAT < 2) ? 1 : $clog2(WB_LAT + 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_READ = 3'd1,
        S_EXEC = 3'd2,
        S_WB   = 3'd3
`ifdef ALU8_MUL_EN
        ,
        S_MUL  = 3'd4
`endif
    } state_e;

    state_e     state_q, state_d;
    logic [2:0] op_q, op_d, rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic [7:0] a_q, a_d, b_q, b_d;
    logic [2:0] waddr_q, waddr_d;
    logic [7:0] wdata_q, wdata_d;
    logic       zero_q, zero_d, carry_q, carry_d;
    logic [2:0] pend_rd_q, pend_rd_d;
    logic [CW-1:0] pend_cnt_q, pend_cnt_d;

`ifdef ALU8_MUL_EN
    logic [15:0] mcand_q, mcand_d, prod_q, prod_d, mul_acc;
    logic [7:0]  mplier_q, mplier_d;
    logic [2:0]  mcnt_q, mcnt_d;
`endif

    logic       illegal;
    logic       hazard;
    logic [7:0] alu_res;
    logic       alu_c;
    logic [8:0] sum_w, diff_w, shl_w, shr_w;

`ifdef ALU8_MUL_EN
    assign illegal = 1'b0;
    assign mul_acc = prod_q + (mplier_q[0] ? mcand_q : 16'd0);
`else
    assign illegal = (op_q == OP_MUL);
`endif

    assign hazard = (pend_cnt_q != '0) && ((pend_rd_q == rs1_q) || (pend_rd_q == rs2_q));

    // Outputs: handshake/strobes decode the state, addresses and data are registered.
    assign instr_ready  = (state_q == S_IDLE);
    assign reg_addr_1   = rs1_q;
    assign reg_addr_2   = rs2_q;
    assign done         = (state_q == S_WB);
    assign write_enable = (state_q == S_WB) && (rd_q != 3'd0) && !illegal;
    assign op_illegal   = (state_q == S_WB) && illegal;
    assign write_addr   = waddr_q;
    assign write_data   = wdata_q;
    assign flag_zero    = zero_q;
    assign flag_carry   = carry_q;

    // Single-cycle ALU on the latched operands; shift carry is the last bit shifted out.
    always_comb begin
        sum_w  = {1'b0, a_q} + {1'b0, b_q};
        diff_w = {1'b0, a_q} - {1'b0, b_q};
        shl_w  = {1'b0, a_q} << b_q[2:0];
        shr_w  = {a_q, 1'b0} >> b_q[2:0];
        alu_res = 8'd0;
        alu_c   = 1'b0;
        case (op_q)
            OP_ADD: begin alu_res = sum_w[7:0];  alu_c = sum_w[8];  end
            OP_SUB: begin alu_res = diff_w[7:0]; alu_c = diff_w[8]; end
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_XOR: alu_res = a_q ^ b_q;
            OP_SHL: begin
                alu_res = shl_w[7:0];
                alu_c   = (b_q[2:0] != 3'd0) && shl_w[8];
            end
            OP_SHR: begin
                alu_res = shr_w[8:1];
                alu_c   = (b_q[2:0] != 3'd0) && shr_w[0];
            end
            default: begin alu_res = 8'd0; alu_c = 1'b0; end
        endcase
    end

    // Next-state and datapath update for the IDLE/READ/EXEC/(MUL)/WB sequence.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rd_d      = rd_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        a_d       = a_q;
        b_d       = b_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        zero_d    = zero_q;
        carry_d   = carry_q;
        pend_rd_d = pend_rd_q;
        pend_cnt_d = (pend_cnt_q != '0) ? pend_cnt_q - CW'(1) : pend_cnt_q;
`ifdef ALU8_MUL_EN
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        mcnt_d   = mcnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    op_d    = instr_op;
                    rd_d    = instr_rd;
                    rs1_d   = instr_rs1;
                    rs2_d   = instr_rs2;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                if (!hazard) begin
                    a_d     = reg_data_1;
                    b_d     = reg_data_2;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
`ifdef ALU8_MUL_EN
                if (op_q == OP_MUL) begin
                    prod_d   = 16'd0;
                    mcand_d  = {8'd0, a_q};
                    mplier_d = b_q;
                    mcnt_d   = 3'd0;
                    state_d  = S_MUL;
                end else begin
                    waddr_d = rd_q;
                    wdata_d = alu_res;
                    zero_d  = (alu_res == 8'd0);
                    carry_d = alu_c;
                    state_d = S_WB;
                end
`else
                // An illegal op leaves result registers and flags untouched.
                if (!illegal) begin
                    waddr_d = rd_q;
                    wdata_d = alu_res;
                    zero_d  = (alu_res == 8'd0);
                    carry_d = alu_c;
                end
                state_d = S_WB;
`endif
            end
`ifdef ALU8_MUL_EN
            S_MUL: begin
                prod_d   = mul_acc;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                mcnt_d   = mcnt_q + 3'd1;
                if (mcnt_q == 3'd7) begin
                    waddr_d = rd_q;
                    wdata_d = mul_acc[7:0];
                    zero_d  = (mul_acc[7:0] == 8'd0);
                    carry_d = (mul_acc[15:8] != 8'd0);
                    state_d = S_WB;
                end
            end
`endif
            S_WB: begin
                state_d = S_IDLE;
                if ((rd_q != 3'd0) && !illegal) begin
                    pend_rd_d  = rd_q;
                    pend_cnt_d = CW'(WB_LAT - 1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any in-flight instruction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            op_q       <= 3'd0;
            rd_q       <= 3'd0;
            rs1_q      <= 3'd0;
            rs2_q      <= 3'd0;
            a_q        <= 8'd0;
            b_q        <= 8'd0;
            waddr_q    <= 3'd0;
            wdata_q    <= 8'd0;
            zero_q     <= 1'b0;
            carry_q    <= 1'b0;
            pend_rd_q  <= 3'd0;
            pend_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            rd_q       <= rd_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            a_q        <= a_d;
            b_q        <= b_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            zero_q     <= zero_d;
            carry_q    <= carry_d;
            pend_rd_q  <= pend_rd_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

`ifdef ALU8_MUL_EN
    // Shift-add multiplier registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand_q  <= 16'd0;
            mplier_q <= 8'd0;
            prod_q   <= 16'd0;
            mcnt_q   <= 3'd0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            mcnt_q   <= mcnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_alu8_exec_stage.sv
// Directed bench for alu8_exec_stage: two instances (WB_LAT=2 and WB_LAT=4),
// each with its own behavioural register bank.
module tb_alu8_exec_stage;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [2:0] op, rd, rs1, rs2;
    logic       valid [2];
    logic       rdy [2], we [2], dn [2], ill [2], fz [2], fc [2];
    logic [2:0] ra1 [2], ra2 [2], wa [2];
    logic [7:0] rd1 [2], rd2 [2], wd [2];
    logic [7:0] bank [2][8];

    logic       pl_we;
    logic [2:0] pl_a;
    logic [7:0] pl_d;

    int total = 0;
    int bad   = 0;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        alu8_exec_stage #(.WB_LAT(gi == 0 ? 2 : 4)) dut (
            .clk(clk), .rst(rst),
            .instr_valid(valid[gi]), .instr_ready(rdy[gi]),
            .instr_op(op), .instr_rd(rd), .instr_rs1(rs1), .instr_rs2(rs2),
            .reg_addr_1(ra1[gi]), .reg_addr_2(ra2[gi]),
            .reg_data_1(rd1[gi]), .reg_data_2(rd2[gi]),
            .write_enable(we[gi]), .write_addr(wa[gi]), .write_data(wd[gi]),
            .done(dn[gi]), .op_illegal(ill[gi]),
            .flag_zero(fz[gi]), .flag_carry(fc[gi])
        );
        assign rd1[gi] = bank[gi][ra1[gi]];
        assign rd2[gi] = bank[gi][ra2[gi]];
    end

    always @(posedge clk) begin
        if (pl_we) begin
            bank[0][pl_a] <= pl_d;
            bank[1][pl_a] <= pl_d;
        end else begin
            for (int i = 0; i < 2; i++)
                if (we[i]) bank[i][wa[i]] <= wd[i];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    logic       c_we, c_ill, c_fz, c_fc;
    logic [2:0] c_wa, c_ra1;
    logic [7:0] c_wd;
    int         cyc;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [2:0] a, input logic [7:0] d);
        pl_a = a; pl_d = d; pl_we = 1'b1;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    task automatic run(input int s, input logic [2:0] o, d, a, b, output int c);
        op = o; rd = d; rs1 = a; rs2 = b; valid[s] = 1'b1;
        for (int k = 0; k < 50 && !rdy[s]; k++) @(negedge clk);
        if (!rdy[s]) chk("ready_wait", {15'd0, rdy[s]}, 16'd1);
        @(posedge clk);
        #1 valid[s] = 1'b0;
        c = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (dn[s]) begin
                c = k; c_we = we[s]; c_ill = ill[s]; c_fz = fz[s]; c_fc = fc[s];
                c_wa = wa[s]; c_wd = wd[s]; c_ra1 = ra1[s];
                break;
            end
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"}, {15'd0, rdy[0]}, 16'd1);
        chk({tag, "_ra"},    {10'd0, ra1[0], ra2[0]}, 16'd0);
        chk({tag, "_we"},    {15'd0, we[0]}, 16'd0);
        chk({tag, "_wa"},    {13'd0, wa[0]}, 16'd0);
        chk({tag, "_wd"},    {8'd0, wd[0]}, 16'd0);
        chk({tag, "_done"},  {14'd0, dn[0], ill[0]}, 16'd0);
        chk({tag, "_flags"}, {14'd0, fz[0], fc[0]}, 16'd0);
    endtask

    initial begin
        rst = 1'b0; valid[0] = 1'b0; valid[1] = 1'b0; pl_we = 1'b0;
        pl_a = 3'd0; pl_d = 8'd0; op = 3'd0; rd = 3'd0; rs1 = 3'd0; rs2 = 3'd0;
        #1 chk_reset("rst0");
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) preload(3'(i), 8'h00);
        preload(3'd1, 8'h0F);
        preload(3'd2, 8'hF3);

        // ADD r3,r1,r2
        run(0, 3'b000, 3'd3, 3'd1, 3'd2, cyc);
        chk("add_cyc", 16'(cyc), 16'd3);
        chk("add_wa", {13'd0, c_wa}, 16'd3);
        chk("add_wd", {8'd0, c_wd}, 16'h02);
        chk("add_we_ill", {14'd0, c_we, c_ill}, 16'b10);
        chk("add_flags", {14'd0, c_fz, c_fc}, 16'b01);
        chk("add_ra1", {13'd0, c_ra1}, 16'd1);
        // SUB r4,r1,r1 -> zero
        run(0, 3'b001, 3'd4, 3'd1, 3'd1, cyc);
        chk("sub0_wd", {8'd0, c_wd}, 16'h00);
        chk("sub0_flags", {14'd0, c_fz, c_fc}, 16'b10);
        // SUB r5,r1,r2 -> borrow
        run(0, 3'b001, 3'd5, 3'd1, 3'd2, cyc);
        chk("sub1_wd", {8'd0, c_wd}, 16'h1C);
        chk("sub1_flags", {14'd0, c_fz, c_fc}, 16'b01);
        // shifts through r7
        preload(3'd7, 8'h03);
        run(0, 3'b101, 3'd6, 3'd2, 3'd7, cyc);
        chk("shl3_wd", {8'd0, c_wd}, 16'h98);
        chk("shl3_c", {15'd0, c_fc}, 16'd1);
        preload(3'd7, 8'h02);
        run(0, 3'b110, 3'd6, 3'd2, 3'd7, cyc);
        chk("shr2_wd", {8'd0, c_wd}, 16'h3C);
        chk("shr2_c", {15'd0, c_fc}, 16'd1);
        preload(3'd7, 8'h08);
        run(0, 3'b101, 3'd6, 3'd2, 3'd7, cyc);
        chk("shl0_wd", {8'd0, c_wd}, 16'hF3);
        chk("shl0_flags", {14'd0, c_fz, c_fc}, 16'b00);
        // back-to-back dependent with WB_LAT=2: no stall
        run(0, 3'b000, 3'd3, 3'd1, 3'd2, cyc);
        run(0, 3'b100, 3'd5, 3'd3, 3'd1, cyc);
        chk("dep2_cyc", 16'(cyc), 16'd3);
        chk("dep2_wd", {8'd0, c_wd}, 16'h0D);
        // MUL r6,r1,r2 after a zero-result SUB
        run(0, 3'b001, 3'd4, 3'd1, 3'd1, cyc);
        run(0, 3'b111, 3'd6, 3'd1, 3'd2, cyc);
`ifdef ALU8_MUL_EN
        chk("mul_cyc", 16'(cyc), 16'd11);
        chk("mul_wd", {8'd0, c_wd}, 16'h3D);
        chk("mul_we_ill", {14'd0, c_we, c_ill}, 16'b10);
        chk("mul_flags", {14'd0, c_fz, c_fc}, 16'b01);
`else
        chk("mul_cyc", 16'(cyc), 16'd3);
        chk("mul_we_ill", {14'd0, c_we, c_ill}, 16'b01);
        chk("mul_flags", {14'd0, c_fz, c_fc}, 16'b10);
        chk("mul_wdata_hold", {5'd0, c_wa, c_wd}, {5'd0, 3'd4, 8'h00});
`endif
        // ADD r0: done without write
        run(0, 3'b000, 3'd0, 3'd1, 3'd2, cyc);
        chk("r0_cyc", 16'(cyc), 16'd3);
        chk("r0_we_ill", {14'd0, c_we, c_ill}, 16'b00);
        chk("r0_flags", {14'd0, c_fz, c_fc}, 16'b01);

        // Reset in the middle of an in-flight instruction
        op = 3'b111; rd = 3'd6; rs1 = 3'd1; rs2 = 3'd2; valid[0] = 1'b1;
        @(posedge clk);
        #1 valid[0] = 1'b0;
`ifdef ALU8_MUL_EN
        for (int k = 0; k < 6; k++) @(negedge clk);
`else
        for (int k = 0; k < 2; k++) @(negedge clk);
`endif
        rst = 1'b0;
        #1 chk_reset("rstmid");
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            chk("post_rst_quiet", {14'd0, dn[0], we[0]}, 16'd0);
        end
        chk("post_rst_ready", {15'd0, rdy[0]}, 16'd1);

        // WB_LAT=4 instance: dependent read stalls twice
        run(1, 3'b000, 3'd3, 3'd1, 3'd2, cyc);
        chk("l4_add_wd", {8'd0, c_wd}, 16'h02);
        run(1, 3'b100, 3'd5, 3'd3, 3'd1, cyc);
        chk("l4_dep_cyc", 16'(cyc), 16'd5);
        chk("l4_dep_wd", {8'd0, c_wd}, 16'h0D);
        run(1, 3'b010, 3'd6, 3'd1, 3'd2, cyc);
        chk("l4_indep_cyc", 16'(cyc), 16'd3);
        chk("l4_indep_wd", {8'd0, c_wd}, 16'h03);
        run(1, 3'b000, 3'd0, 3'd1, 3'd2, cyc);
        chk("l4_r0_we", {15'd0, c_we}, 16'd0);
        run(1, 3'b011, 3'd4, 3'd0, 3'd1, cyc);
        chk("l4_r0_read_cyc", 16'(cyc), 16'd3);
        chk("l4_r0_read_wd", {8'd0, c_wd}, 16'h0F);
        run(1, 3'b111, 3'd6, 3'd1, 3'd2, cyc);
        run(1, 3'b011, 3'd4, 3'd6, 3'd1, cyc);
`ifdef ALU8_MUL_EN
        chk("l4_mul_dep_cyc", 16'(cyc), 16'd5);
        chk("l4_mul_dep_wd", {8'd0, c_wd}, 16'h3F);
`else
        chk("l4_mul_dep_cyc", 16'(cyc), 16'd3);
        chk("l4_mul_dep_wd", {8'd0, c_wd}, 16'h0F);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
